// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with optional input synchronizer and parameterised bit period
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int N  = CLKS_PER_BIT;
    localparam int H  = (N - 1) / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((H > 0) ? H - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          w_rx_s;
    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [3:0]    r_bit, w_bit_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic [7:0]    r_data;
    logic          r_valid, r_err, r_busy;
    logic          w_done, w_bad;

    // Synchronizer flops preset to idle-high so reset never looks like a start bit.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_rx_s = rx_line;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '1;
                end else begin
                    r_sync[0] <= rx_line;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_rx_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_valid <= w_done;
            r_err   <= w_bad;
            r_busy  <= (w_state_nx != IDLE);
            if (w_done) begin
                r_data <= r_shift;
            end
        end
    end

    // With H = 0 the start check coincides with the falling edge, so START is skipped.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_done     = 1'b0;
        w_bad      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_nx   = '0;
                    w_bit_nx   = '0;
                    w_state_nx = (H == 0) ? DATA : START;
                end
            end
            START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nx   = '0;
                    w_state_nx = w_rx_s ? IDLE : DATA;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = '0;
                    w_shift_nx = {w_rx_s, r_shift[7:1]};
                    if (r_bit == 4'd7) begin
                        w_bit_nx   = '0;
                        w_state_nx = STOP;
                    end else begin
                        w_bit_nx = r_bit + 4'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                    w_done     = w_rx_s;
                    w_bad      = !w_rx_s;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - bench for uart_rx: three parameterisations against a timestamp-based frame model
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst  [3];
    logic       rx   [3];
    logic [7:0] dout [3];
    logic       dv   [3];
    logic       fe   [3];
    logic       bz   [3];

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NP = (g == 0) ? 1 : (g == 1) ? 16 : 4;
        localparam int SP = (g == 1) ? 2 : 0;
        uart_rx #(.CLKS_PER_BIT(NP), .SYNC_STAGES(SP)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .rx_line    (rx[g]),
            .data_out   (dout[g]),
            .data_valid (dv[g]),
            .frame_err  (fe[g]),
            .busy       (bz[g])
        );
    end

    function automatic int n_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 16 : 4;
    endfunction

    function automatic int s_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Model: line and reset history per cycle; frames located by absolute sample instants.
    bit         line_h [3][0:4095];
    bit         rst_h  [3][0:4095];
    bit         m_act  [3];
    int         m_t0   [3];
    logic [7:0] m_acc  [3];
    bit         e_known[3];
    logic [7:0] e_data [3];
    bit         e_dv   [3];
    bit         e_fe   [3];
    bit         e_busy [3];

    function automatic bit rxs(input int i, input int c);
        int s;
        s = s_of(i);
        if (s == 0) return line_h[i][c];
        for (int j = c - s; j < c; j++) begin
            if (j < 0 || rst_h[i][j]) return 1'b1;
        end
        return line_h[i][c - s];
    endfunction

    task automatic model_step(input int i);
        int n, h, off, k;
        bit s;
        n = n_of(i);
        h = (n - 1) / 2;
        line_h[i][cyc] = rx[i];
        rst_h[i][cyc]  = rst[i];
        if (rst[i]) begin
            e_known[i] = 1'b1;
            m_act[i]   = 1'b0;
            e_data[i]  = 8'h00;
            e_dv[i]    = 1'b0;
            e_fe[i]    = 1'b0;
            e_busy[i]  = 1'b0;
        end else begin
            e_dv[i] = 1'b0;
            e_fe[i] = 1'b0;
            s = rxs(i, cyc);
            if (!m_act[i] && !s) begin
                m_act[i] = 1'b1;
                m_t0[i]  = cyc;
            end
            if (m_act[i]) begin
                off = cyc - m_t0[i];
                if (off == h && s) begin
                    m_act[i] = 1'b0;
                end else if (off > h && (off - h) % n == 0) begin
                    k = (off - h) / n;
                    if (k <= 8) begin
                        m_acc[i][k-1] = s;
                    end else begin
                        if (s) begin
                            e_data[i] = m_acc[i];
                            e_dv[i]   = 1'b1;
                        end else begin
                            e_fe[i] = 1'b1;
                        end
                        m_act[i] = 1'b0;
                    end
                end
            end
            e_busy[i] = m_act[i];
        end
    endtask

    always @(posedge clk) begin
        if (cyc >= 4095) begin
            $display("FAIL cycle budget exceeded at cycle %0d", cyc);
            $fatal(1);
        end
        for (int i = 0; i < 3; i++) model_step(i);
        cyc++;
    end

    // Event logs used by the directed literal checks.
    int         dv_n [3];
    int         dv_c [3][8];
    logic [7:0] dv_d [3][8];
    int         fe_n [3];
    int         fe_c [3][4];
    int         bz_n [3];
    int         bz_f [3];
    int         bz_l [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (e_known[i]) begin
                chk($sformatf("model dut%0d data_out", i), dout[i], e_data[i]);
                chk($sformatf("model dut%0d data_valid", i), dv[i], e_dv[i]);
                chk($sformatf("model dut%0d frame_err", i), fe[i], e_fe[i]);
                chk($sformatf("model dut%0d busy", i), bz[i], e_busy[i]);
            end
            if (dv[i] === 1'b1) begin
                if (dv_n[i] < 8) begin
                    dv_c[i][dv_n[i]] = cyc;
                    dv_d[i][dv_n[i]] = dout[i];
                end
                dv_n[i]++;
            end
            if (fe[i] === 1'b1) begin
                if (fe_n[i] < 4) fe_c[i][fe_n[i]] = cyc;
                fe_n[i]++;
            end
            if (bz[i] === 1'b1) begin
                if (bz_f[i] < 0) bz_f[i] = cyc;
                bz_l[i] = cyc;
                bz_n[i]++;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log(input int i);
        dv_n[i] = 0;
        fe_n[i] = 0;
        bz_n[i] = 0;
        bz_f[i] = -1;
        bz_l[i] = -1;
    endtask

    task automatic send(input int i, input logic [7:0] b, input bit stop_b);
        int n;
        n = n_of(i);
        rx[i] = 1'b0;
        tick(n);
        for (int k = 0; k < 8; k++) begin
            rx[i] = b[k];
            tick(n);
        end
        rx[i] = stop_b;
        tick(n);
        rx[i] = 1'b1;
    endtask

    initial begin
        int t;
        logic [7:0] v;
        for (int i = 0; i < 3; i++) begin
            rst[i]     = 1'b1;
            rx[i]      = 1'b1;
            e_known[i] = 1'b0;
            m_act[i]   = 1'b0;
            clear_log(i);
        end
        tick(3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset dut%0d data_out", i), dout[i], 8'h00);
            chk($sformatf("reset dut%0d data_valid", i), dv[i], 1'b0);
            chk($sformatf("reset dut%0d frame_err", i), fe[i], 1'b0);
            chk($sformatf("reset dut%0d busy", i), bz[i], 1'b0);
            rst[i] = 1'b0;
        end
        tick(2);

        // Single 0xA5 frame at N=1: valid exactly 10 cycles after the start edge.
        clear_log(0);
        t = cyc;
        send(0, 8'hA5, 1'b1);
        tick(3);
        chk("a5 valid count", dv_n[0], 1);
        chk("a5 valid cycle", dv_c[0][0], t + 10);
        chk("a5 data", dv_d[0][0], 8'hA5);
        chk("a5 busy first", bz_f[0], t + 1);
        chk("a5 busy last", bz_l[0], t + 9);
        chk("a5 busy cycles", bz_n[0], 9);

        // Back-to-back frames with no idle gap.
        clear_log(0);
        t = cyc;
        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b1);
        send(0, 8'h3C, 1'b1);
        tick(3);
        chk("b2b valid count", dv_n[0], 3);
        chk("b2b ferr count", fe_n[0], 0);
        chk("b2b busy cycles", bz_n[0], 27);
        for (int k = 0; k < 3; k++) begin
            v = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h3C;
            chk($sformatf("b2b valid cycle %0d", k), dv_c[0][k], t + 10 * (k + 1));
            chk($sformatf("b2b data %0d", k), dv_d[0][k], v);
        end

        // N=16, S=2: good byte, then 0x81 with a low stop bit.
        send(1, 8'h42, 1'b1);
        tick(40);
        clear_log(1);
        t = cyc;
        send(1, 8'h81, 1'b0);
        tick(20);
        chk("ferr count", fe_n[1], 1);
        chk("ferr cycle", fe_c[1][0], t + 2 + 7 + 144 + 1);
        chk("ferr no valid", dv_n[1], 0);
        chk("ferr data held", dout[1], 8'h42);
        tick(200);

        // N=16: 3-cycle glitch is rejected at the half-bit sample.
        clear_log(1);
        t = cyc;
        rx[1] = 1'b0;
        tick(3);
        rx[1] = 1'b1;
        tick(30);
        chk("glitch busy cycles", bz_n[1], 7);
        chk("glitch busy first", bz_f[1], t + 3);
        chk("glitch no valid", dv_n[1], 0);
        chk("glitch no ferr", fe_n[1], 0);
        chk("glitch idle", bz[1], 1'b0);

        // N=4: reset during d3 of 0x5A, then 0xC3.
        send(2, 8'h11, 1'b1);
        tick(5);
        chk("n4 first data", dout[2], 8'h11);
        clear_log(2);
        rx[2] = 1'b0; tick(4);
        rx[2] = 1'b0; tick(4);
        rx[2] = 1'b1; tick(4);
        rx[2] = 1'b0; tick(4);
        rx[2] = 1'b1; tick(1);
        rst[2] = 1'b1;
        rx[2]  = 1'b1;
        tick(1);
        rst[2] = 1'b0;
        chk("abort data_out", dout[2], 8'h00);
        chk("abort valid", dv[2], 1'b0);
        chk("abort ferr", fe[2], 1'b0);
        chk("abort busy", bz[2], 1'b0);
        tick(60);
        chk("abort no valid", dv_n[2], 0);
        chk("abort no ferr", fe_n[2], 0);
        clear_log(2);
        t = cyc;
        send(2, 8'hC3, 1'b1);
        tick(5);
        chk("c3 valid count", dv_n[2], 1);
        chk("c3 valid cycle", dv_c[2][0], t + 38);
        chk("c3 data", dv_d[2][0], 8'hC3);

        // Line held low through reset: frame begins on the first cycle out of reset.
        clear_log(2);
        rst[2] = 1'b1;
        rx[2]  = 1'b0;
        tick(3);
        rst[2] = 1'b0;
        t = cyc;
        tick(4);
        v = 8'h96;
        for (int k = 0; k < 8; k++) begin
            rx[2] = v[k];
            tick(4);
        end
        rx[2] = 1'b1;
        tick(10);
        chk("lowrst valid count", dv_n[2], 1);
        chk("lowrst ferr count", fe_n[2], 0);
        chk("lowrst valid cycle", dv_c[2][0], t + 38);
        chk("lowrst data", dv_d[2][0], 8'h96);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
